// File: rtl/seq_shl_if.sv
// Handshake and data bus of the multi-cycle left shifter seq_shl.
// The scheduler drives through the master side; the shifter sits on the slave side.
// Build macro SEQ_SHL_OVF_EN adds the overflow flag to the bus.
interface seq_shl_if #(
    parameter int DATAWIDTH = 16
);
    logic                 start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] sh_amt;
    logic [DATAWIDTH-1:0] d;
    logic                 busy;
    logic                 done;
`ifdef SEQ_SHL_OVF_EN
    logic                 ovf;

    modport master (output start, a, sh_amt, input d, busy, done, ovf);
    modport slave  (input start, a, sh_amt, output d, busy, done, ovf);
`else
    modport master (output start, a, sh_amt, input d, busy, done);
    modport slave  (input start, a, sh_amt, output d, busy, done);
`endif
endinterface

// File: rtl/seq_shl.sv
// seq_shl: multi-cycle logical left shifter, at most STEP bits per clock,
// controlled by a start/busy/done handshake.
// Optional build macro SEQ_SHL_OVF_EN: adds the 'ovf' output, the OR of all
// bits shifted out past the MSB during an operation.
module seq_shl #(
    parameter int DATAWIDTH = 16,
    parameter int STEP      = 1
) (
    input  logic      Clk,
    input  logic      Rst,
    seq_shl_if.slave  bus
);

    // rem must be able to hold DATAWIDTH itself, the clamped maximum amount
    localparam int RW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATAWIDTH-1:0] acc;
    logic [RW-1:0]        rem;
    logic [RW-1:0]        amt_clamped;
    logic [RW-1:0]        k;
    logic [RW-1:0]        rem_next;
    logic [DATAWIDTH-1:0] acc_shifted;
    logic                 accept;
    logic                 finish;

`ifdef SEQ_SHL_OVF_EN
    logic [DATAWIDTH+STEP-1:0] wide;
    logic                      out_bits;
    logic                      ovf_acc;
`endif

    // Clamp the requested amount so large values never wrap around
    always_comb begin
        amt_clamped = bus.sh_amt[RW-1:0];
        if (bus.sh_amt >= DATAWIDTH'(DATAWIDTH))
            amt_clamped = RW'(DATAWIDTH);
    end

    // Per-cycle shift step: k = min(rem, STEP), plus the shifted working value
    always_comb begin
        k = (rem < RW'(STEP)) ? rem : RW'(STEP);
        rem_next = rem - k;
`ifdef SEQ_SHL_OVF_EN
        wide        = {{STEP{1'b0}}, acc} << k;
        acc_shifted = wide[DATAWIDTH-1:0];
        out_bits    = |wide[DATAWIDTH+STEP-1:DATAWIDTH];
`else
        acc_shifted = acc << k;
`endif
    end

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode; start is only honoured in IDLE or DONE
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (amt_clamped == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (rem_next == '0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers and result register; d only moves on a result load
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc   <= '0;
            rem   <= '0;
            bus.d <= '0;
        end else if (accept) begin
            acc <= bus.a;
            rem <= amt_clamped;
            if (amt_clamped == '0)
                bus.d <= bus.a;
        end else if (state == SHIFT) begin
            acc <= acc_shifted;
            rem <= rem_next;
            if (finish)
                bus.d <= acc_shifted;
        end
    end

`ifdef SEQ_SHL_OVF_EN
    // Sticky record of bits lost past the MSB, published together with d
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ovf_acc <= 1'b0;
            bus.ovf <= 1'b0;
        end else if (accept) begin
            ovf_acc <= 1'b0;
            if (amt_clamped == '0)
                bus.ovf <= 1'b0;
        end else if (state == SHIFT) begin
            ovf_acc <= ovf_acc | out_bits;
            if (finish)
                bus.ovf <= ovf_acc | out_bits;
        end
    end
`endif

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

endmodule

// File: doc/seq_shl.md
Name: seq_shl

Overview:
- Multi-cycle left shifter for the datapath component library; the left-shift counterpart of the combinational right shifter.
- Shifts operand `a` left by `sh_amt`, at most STEP bits per clock, under a start/busy/done handshake.
- Used where a full-width barrel shifter is too costly. The scheduler issues `start` and waits for `done`.

Parameters:
- DATAWIDTH, 16, width of `a`, `sh_amt` and `d`.
- STEP, 1, maximum bits shifted per clock. Must be a power of two, 1..DATAWIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on Clk rise while in IDLE or DONE.
- a  input  DATAWIDTH  operand; captured on the accepted start edge.
- sh_amt  input  DATAWIDTH  shift amount, unsigned; captured with `a`.
- d  output  DATAWIDTH  result register; holds its value until the next result load.
- busy  output  1  high while in SHIFT.
- done  output  1  high for exactly one cycle, while in DONE.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, acc=0, rem=0, d=0, busy=0, done=0. Reset mid-SHIFT aborts the operation with no done pulse.
- Internal registers:
  - acc, DATAWIDTH bits, working value.
  - rem, remaining shift count. rem is clamped: rem = (sh_amt >= DATAWIDTH) ? DATAWIDTH : sh_amt.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE); both are registered-state decodes.
- IDLE:
  - start=1: acc<=a, rem<=clamped sh_amt.
  - If the clamped amount is 0, load d<=a and go to DONE; otherwise go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - k = min(rem, STEP); acc <= acc << k (zero fill); rem <= rem - k.
  - When rem-k == 0: d <= acc << k in the same edge, then go to DONE.
  - start is ignored in SHIFT; `a` and `sh_amt` may change freely.
- DONE:
  - start=1: accepted exactly as in IDLE. Back-to-back operation: done stays high if the new amount is 0, otherwise goes to SHIFT.
  - start=0: go to IDLE.
- Latency:
  - Define E0 as the start-accept edge. done becomes visible after edge E0+ceil(rem/STEP).
  - For rem=0, done is high in the cycle right after E0.
- Arithmetic:
  - Logical shift, unsigned; bits shifted past the MSB are discarded.
  - Any sh_amt >= DATAWIDTH yields d=0 after ceil(DATAWIDTH/STEP) shift cycles.
  - The upper bits of sh_amt never cause wrap-around.
- d changes only on a result-load edge; it holds across IDLE and SHIFT.

Optional Feature:
- Macro: SEQ_SHL_OVF_EN.
- Defined:
  - Extra output port `ovf`, input... correction: output, 1 bit, reset 0.
  - ovf is the OR of every bit shifted out of the MSB during the operation. Equivalently, ovf=1 iff a[DATAWIDTH-1 : DATAWIDTH-rem] != 0, and ovf=(a!=0) when clamped rem = DATAWIDTH.
  - Cleared on each accepted start; loaded together with d; held with d.
  - For rem=0, ovf=0.
- Not defined: the `ovf` port and its logic are absent; all other behaviour is identical.

Test Plan:
- DATAWIDTH=16, STEP=1: a=16'h0003, sh_amt=4, start pulse -> busy high 4 cycles; done after E0+4; d=16'h0030, held afterwards.
- STEP=4: a=16'h00F1, sh_amt=6 -> 2 SHIFT cycles (shifts of 4 then 2); d=16'h3C40. With SEQ_SHL_OVF_EN: ovf=0.
- sh_amt=0, a=16'hBEEF -> no busy; done in the cycle after E0; d=16'hBEEF. sh_amt=16'hFFFF, a=16'h0001, STEP=1 -> 16 SHIFT cycles; d=0; ovf=1.
- Start pulses during SHIFT, with a and sh_amt changed, are ignored -> the original result is delivered. A start held high in DONE with a=16'h0001, sh_amt=1 launches immediately -> next d=16'h0002.
- Rst low for one cycle mid-SHIFT -> d=0, busy=0, done=0 asynchronously; no done pulse follows until a new start.
- With SEQ_SHL_OVF_EN: a=16'h8001, sh_amt=1 -> d=16'h0002, ovf=1; next op a=16'h0001, sh_amt=1 -> ovf=0.
